// File: rtl/uart_frame_ctrl_if.sv
// Frame controller bus: frame request, sample stream and UART byte port.
// master is the controller side; slave is the host/transmitter side.
interface uart_frame_ctrl_if;
    logic        i_frame_start;
    logic        o_frame_busy;
    logic        o_frame_done;
    logic [15:0] i_smp_data;
    logic        i_smp_valid;
    logic        o_smp_ready;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;

    modport master (
        input  i_frame_start,
        input  i_smp_data,
        input  i_smp_valid,
        input  i_tx_busy,
        output o_frame_busy,
        output o_frame_done,
        output o_smp_ready,
        output o_tx_start,
        output o_tx_data
    );

    modport slave (
        output i_frame_start,
        output i_smp_data,
        output i_smp_valid,
        output i_tx_busy,
        input  o_frame_busy,
        input  o_frame_done,
        input  o_smp_ready,
        input  o_tx_start,
        input  o_tx_data
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Builds HDR0 HDR1 LEN payload CHK frames from 16-bit samples
// and paces them byte by byte into a UART transmitter.
module uart_frame_ctrl #(
    parameter int         N_SAMPLES = 16,
    parameter logic [7:0] HDR0      = 8'hAA,
    parameter logic [7:0] HDR1      = 8'h55
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_frame_ctrl_if.master bus
);

    localparam logic [7:0] LEN  = 8'(N_SAMPLES);
    localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO
    } state_t;

    typedef enum logic [2:0] {
        K_HDR0, K_HDR1, K_LEN, K_PHI, K_PLO, K_CHK
    } kind_t;

    state_t     state_q;
    kind_t      kind_q;
    logic [7:0] byte_q;
    logic [7:0] smp_lo_q;
    logic [7:0] cnt_q;
    logic [7:0] chk_q;
    logic [1:0] guard_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic       done_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            kind_q     <= K_HDR0;
            byte_q     <= 8'h00;
            smp_lo_q   <= 8'h00;
            cnt_q      <= 8'h00;
            chk_q      <= 8'h00;
            guard_q    <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    // a request coinciding with the done pulse is dropped
                    if (bus.i_frame_start && !done_q) begin
                        chk_q   <= 8'h00;
                        cnt_q   <= 8'h00;
                        guard_q <= 2'd0;
                        kind_q  <= K_HDR0;
                        byte_q  <= HDR0;
                        state_q <= ISSUE;
                    end
                end
                FETCH: begin
                    if (bus.i_smp_valid) begin
                        smp_lo_q <= bus.i_smp_data[7:0];
                        byte_q   <= bus.i_smp_data[15:8];
                        kind_q   <= K_PHI;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.i_tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= byte_q;
                        if (kind_q inside {K_LEN, K_PHI, K_PLO})
                            chk_q <= chk_q ^ byte_q;
                        guard_q <= 2'd0;
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // give up on busy after three quiet cycles
                    if (bus.i_tx_busy || guard_q == 2'd2)
                        state_q <= WAIT_LO;
                    else
                        guard_q <= guard_q + 2'd1;
                end
                WAIT_LO: begin
                    if (!bus.i_tx_busy) begin
                        case (kind_q)
                            K_HDR0: begin
                                byte_q  <= HDR1;
                                kind_q  <= K_HDR1;
                                state_q <= ISSUE;
                            end
                            K_HDR1: begin
                                byte_q  <= LEN;
                                kind_q  <= K_LEN;
                                state_q <= ISSUE;
                            end
                            K_LEN: state_q <= FETCH;
                            K_PHI: begin
                                byte_q  <= smp_lo_q;
                                kind_q  <= K_PLO;
                                state_q <= ISSUE;
                            end
                            K_PLO: begin
                                if (cnt_q == LAST) begin
                                    byte_q  <= chk_q;
                                    kind_q  <= K_CHK;
                                    state_q <= ISSUE;
                                end else begin
                                    cnt_q   <= cnt_q + 8'd1;
                                    state_q <= FETCH;
                                end
                            end
                            K_CHK: begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_smp_ready  = (state_q == FETCH);
    assign bus.o_frame_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomized bench for uart_frame_ctrl with a UART busy model
// and a byte-stream reference built from the frame rules.
module tb_uart_frame_ctrl;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] sq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_frame_ctrl_if ifa ();
    uart_frame_ctrl_if ifb ();

    uart_frame_ctrl #(.N_SAMPLES(2)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa)
    );

    uart_frame_ctrl #(.N_SAMPLES(1)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bq_t  got_a, got_b;
    int   done_a = 0, done_b = 0, viol_a = 0;
    logic busy_a = 1'b0, force_a = 1'b0;
    int   dly_a = 0, len_a = 20;

    assign ifa.i_tx_busy = busy_a | force_a;
    assign ifb.i_tx_busy = 1'b0;

    always @(posedge clk) begin
        if (ifa.o_tx_start) begin
            got_a.push_back(ifa.o_tx_data);
            if (force_a) viol_a++;
        end
        if (ifa.o_frame_done) done_a++;
        if (ifb.o_tx_start) got_b.push_back(ifb.o_tx_data);
        if (ifb.o_frame_done) done_b++;
    end

    // UART transmitter model for instance A
    initial forever begin
        @(posedge clk);
        if (ifa.o_tx_start) begin
            repeat (dly_a) @(posedge clk);
            #1 busy_a = 1'b1;
            repeat (len_a) @(posedge clk);
            #1 busy_a = 1'b0;
        end
    end

    function automatic bq_t expect_frame(input int n, input sq_t s);
        bq_t q;
        logic [7:0] c;
        q = {};
        c = 8'(n);
        q.push_back(8'hAA);
        q.push_back(8'h55);
        q.push_back(8'(n));
        foreach (s[k]) begin
            q.push_back(s[k][15:8]);
            q.push_back(s[k][7:0]);
            c = c ^ s[k][15:8] ^ s[k][7:0];
        end
        q.push_back(c);
        return q;
    endfunction

    task automatic pulse_start_a();
        @(negedge clk);
        ifa.i_frame_start = 1'b1;
        @(negedge clk);
        ifa.i_frame_start = 1'b0;
    endtask

    task automatic feed_a(input logic [15:0] s, output bit to);
        @(negedge clk);
        ifa.i_smp_data  = s;
        ifa.i_smp_valid = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (ifa.o_smp_ready) begin
                to = 1'b0;
                break;
            end
        end
        #1 ifa.i_smp_valid = 1'b0;
    endtask

    task automatic wait_done_a(output bit to);
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ifa.o_frame_done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ifa.o_tx_start, ifa.o_tx_data, ifa.o_smp_ready,
             ifa.o_frame_busy, ifa.o_frame_done} !== 12'h000)
            $display("FAIL reset_a: got %b want 0", {ifa.o_tx_start,
                     ifa.o_tx_data, ifa.o_smp_ready,
                     ifa.o_frame_busy, ifa.o_frame_done});
        else n_pass++;
        n_checks++;
        if ({ifb.o_tx_start, ifb.o_tx_data, ifb.o_smp_ready,
             ifb.o_frame_busy, ifb.o_frame_done} !== 12'h000)
            $display("FAIL reset_b: got %b want 0", {ifb.o_tx_start,
                     ifb.o_tx_data, ifb.o_smp_ready,
                     ifb.o_frame_busy, ifb.o_frame_done});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bq_t exp;
        bit  t0, t1, t2, bad;
        dly_a = 0;
        len_a = 20;
        got_a.delete();
        done_a = 0;
        pulse_start_a();
        feed_a(16'h1234, t0);
        feed_a(16'hABCD, t1);
        wait_done_a(t2);
        repeat (30) @(negedge clk);
        n_checks++;
        if (t0 | t1 | t2) $display("FAIL basic_timeout: got %b%b%b want 000", t0, t1, t2);
        else n_pass++;
        exp = expect_frame(2, '{16'h1234, 16'hABCD});
        bad = (got_a.size() != exp.size());
        if (!bad) foreach (exp[i]) if (got_a[i] !== exp[i]) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL basic_stream: got %p want %p", got_a, exp);
        else n_pass++;
        n_checks++;
        if (got_a.size() != 8) $display("FAIL basic_starts: got %0d want 8", got_a.size());
        else n_pass++;
        n_checks++;
        if (done_a != 1) $display("FAIL basic_done: got %0d want 1", done_a);
        else n_pass++;
    endtask

    task automatic test_stall();
        bq_t exp;
        bit  t0, t1, t2, t3, bad;
        int  low_cnt, n_before;
        got_a.delete();
        done_a = 0;
        pulse_start_a();
        feed_a(16'h1234, t0);
        t1 = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ifa.o_smp_ready) begin
                t1 = 1'b0;
                break;
            end
        end
        n_before = got_a.size();
        low_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifa.o_smp_ready !== 1'b1) low_cnt++;
        end
        n_checks++;
        if (low_cnt != 0) $display("FAIL stall_ready: got %0d low cycles want 0", low_cnt);
        else n_pass++;
        n_checks++;
        if (got_a.size() != n_before || t1)
            $display("FAIL stall_starts: got %0d bytes want %0d", got_a.size(), n_before);
        else n_pass++;
        feed_a(16'hABCD, t2);
        wait_done_a(t3);
        repeat (30) @(negedge clk);
        exp = expect_frame(2, '{16'h1234, 16'hABCD});
        bad = t0 | t2 | t3 | (got_a.size() != exp.size());
        if (!bad) foreach (exp[i]) if (got_a[i] !== exp[i]) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL stall_stream: got %p want %p", got_a, exp);
        else n_pass++;
    endtask

    task automatic test_dup_start();
        bq_t exp;
        bit  t0, t1, t2, bad;
        got_a.delete();
        done_a = 0;
        pulse_start_a();
        feed_a(16'h1234, t0);
        pulse_start_a();
        feed_a(16'hABCD, t1);
        wait_done_a(t2);
        repeat (200) @(negedge clk);
        exp = expect_frame(2, '{16'h1234, 16'hABCD});
        bad = t0 | t1 | t2 | (got_a.size() != exp.size());
        if (!bad) foreach (exp[i]) if (got_a[i] !== exp[i]) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL dup_stream: got %p want %p", got_a, exp);
        else n_pass++;
        n_checks++;
        if (done_a != 1 || ifa.o_frame_busy !== 1'b0)
            $display("FAIL dup_second_frame: got done=%0d busy=%b want 1/0",
                     done_a, ifa.o_frame_busy);
        else n_pass++;
    endtask

    task automatic test_busy_hold();
        bq_t exp;
        bit  t0, t1, t2, bad;
        got_a.delete();
        done_a = 0;
        viol_a = 0;
        @(negedge clk);
        force_a = 1'b1;
        pulse_start_a();
        repeat (50) @(negedge clk);
        n_checks++;
        if (got_a.size() != 0) $display("FAIL busy_early_start: got %0d want 0", got_a.size());
        else n_pass++;
        force_a = 1'b0;
        feed_a(16'h1234, t0);
        feed_a(16'hABCD, t1);
        wait_done_a(t2);
        repeat (30) @(negedge clk);
        n_checks++;
        if (viol_a != 0) $display("FAIL busy_violation: got %0d want 0", viol_a);
        else n_pass++;
        exp = expect_frame(2, '{16'h1234, 16'hABCD});
        bad = t0 | t1 | t2 | (got_a.size() != exp.size());
        if (!bad) foreach (exp[i]) if (got_a[i] !== exp[i]) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL busy_stream: got %p want %p", got_a, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bq_t exp;
        bit  t0, t1, t2, t3, t4, t5, t6, t7, bad;
        logic [15:0] s0, s1;
        pulse_start_a();
        feed_a(16'h0F0F, t0);
        feed_a(16'hF0F0, t1);
        wait_done_a(t2);
        ifa.i_frame_start = 1'b1;
        @(posedge clk);
        #1 ifa.i_frame_start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.o_frame_busy !== 1'b0)
            $display("FAIL start_on_done: got busy=%b want 0", ifa.o_frame_busy);
        else n_pass++;
        pulse_start_a();
        feed_a(16'h1111, t3);
        feed_a(16'h2222, t4);
        wait_done_a(t5);
        @(posedge clk);
        #1 ifa.i_frame_start = 1'b1;
        got_a.delete();
        @(posedge clk);
        #1 ifa.i_frame_start = 1'b0;
        n_checks++;
        if (ifa.o_frame_busy !== 1'b1 || t0 | t1 | t2 | t3 | t4 | t5)
            $display("FAIL b2b_accept: got busy=%b want 1", ifa.o_frame_busy);
        else n_pass++;
        s0 = 16'($urandom);
        s1 = 16'($urandom);
        feed_a(s0, t6);
        feed_a(s1, t7);
        wait_done_a(t2);
        repeat (30) @(negedge clk);
        exp = expect_frame(2, '{s0, s1});
        bad = t6 | t7 | t2 | (got_a.size() != exp.size());
        if (!bad) foreach (exp[i]) if (got_a[i] !== exp[i]) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL b2b_stream: got %p want %p", got_a, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bq_t exp;
        bit  t0, t1, t2, t3, bad;
        logic [15:0] s0, s1;
        got_a.delete();
        done_a = 0;
        pulse_start_a();
        feed_a(16'h1234, t0);
        t1 = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (got_a.size() >= 4) begin
                t1 = 1'b0;
                break;
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ifa.o_tx_start, ifa.o_tx_data, ifa.o_smp_ready,
             ifa.o_frame_busy, ifa.o_frame_done} !== 12'h000 || t0 | t1)
            $display("FAIL reset_mid_outputs: got %b want 0", {ifa.o_tx_start,
                     ifa.o_tx_data, ifa.o_smp_ready,
                     ifa.o_frame_busy, ifa.o_frame_done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (done_a != 0) $display("FAIL reset_mid_done: got %0d want 0", done_a);
        else n_pass++;
        got_a.delete();
        s0 = 16'($urandom);
        s1 = 16'($urandom);
        pulse_start_a();
        feed_a(s0, t0);
        feed_a(s1, t2);
        wait_done_a(t3);
        repeat (30) @(negedge clk);
        exp = expect_frame(2, '{s0, s1});
        bad = t0 | t2 | t3 | (got_a.size() != exp.size());
        if (!bad) foreach (exp[i]) if (got_a[i] !== exp[i]) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL reset_mid_stream: got %p want %p", got_a, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        bq_t exp;
        bit  t0, t1, t2, bad;
        logic [15:0] s0, s1;
        int stall;
        for (int it = 0; it < 8; it++) begin
            s0 = 16'($urandom);
            s1 = 16'($urandom);
            dly_a = int'($urandom_range(0, 1));
            len_a = int'($urandom_range(1, 20));
            stall = int'($urandom_range(0, 30));
            got_a.delete();
            done_a = 0;
            pulse_start_a();
            feed_a(s0, t0);
            repeat (stall) @(negedge clk);
            feed_a(s1, t1);
            wait_done_a(t2);
            repeat (30) @(negedge clk);
            exp = expect_frame(2, '{s0, s1});
            bad = t0 | t1 | t2 | (got_a.size() != exp.size());
            if (!bad) foreach (exp[i]) if (got_a[i] !== exp[i]) bad = 1'b1;
            n_checks++;
            if (bad) $display("FAIL rand_stream_%0d: got %p want %p", it, got_a, exp);
            else n_pass++;
            n_checks++;
            if (done_a != 1) $display("FAIL rand_done_%0d: got %0d want 1", it, done_a);
            else n_pass++;
        end
        dly_a = 0;
        len_a = 20;
    endtask

    task automatic test_lost_start();
        bq_t exp;
        bit  to, bad;
        logic [15:0] s;
        for (int it = 0; it < 3; it++) begin
            s = (it == 0) ? 16'h0000 : 16'($urandom);
            got_b.delete();
            done_b = 0;
            @(negedge clk);
            ifb.i_frame_start = 1'b1;
            @(negedge clk);
            ifb.i_frame_start = 1'b0;
            ifb.i_smp_data  = s;
            ifb.i_smp_valid = 1'b1;
            to = 1'b1;
            for (int i = 0; i < 500; i++) begin
                @(posedge clk);
                if (ifb.o_smp_ready) begin
                    to = 1'b0;
                    break;
                end
            end
            #1 ifb.i_smp_valid = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (ifb.o_frame_done) break;
            end
            repeat (5) @(negedge clk);
            exp = expect_frame(1, '{s});
            bad = to | (got_b.size() != exp.size());
            if (!bad) foreach (exp[i]) if (got_b[i] !== exp[i]) bad = 1'b1;
            n_checks++;
            if (bad) $display("FAIL lost_stream_%0d: got %p want %p", it, got_b, exp);
            else n_pass++;
            n_checks++;
            if (done_b != 1) $display("FAIL lost_done_%0d: got %0d want 1", it, done_b);
            else n_pass++;
        end
    endtask

    initial begin
        ifa.i_frame_start = 1'b0;
        ifa.i_smp_valid   = 1'b0;
        ifa.i_smp_data    = 16'h0000;
        ifb.i_frame_start = 1'b0;
        ifb.i_smp_valid   = 1'b0;
        ifb.i_smp_data    = 16'h0000;
        test_reset();
        test_basic();
        test_stall();
        test_dup_start();
        test_busy_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_lost_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
